// File: rtl/axis_arb_pkg.sv
// Shared types and width helpers for the packet-granular AXI4-Stream arbiter.
package axis_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  // Width of an index that selects one of n items (at least 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a beat counter that must hold max_beats + 1.
  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats + 2);
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_select.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping modulo NUM_SRC.
module rr_select
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [SRC_W-1:0]   grant_idx,
  output logic               valid
);

  function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return SRC_W'(s);
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the search so no path infers a latch.
    grant_idx = '0;
    valid     = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (!valid && req[wrap_idx(ptr, i)]) begin
        valid     = 1'b1;
        grant_idx = wrap_idx(ptr, i);
      end
    end
    grant = valid ? (NUM_SRC'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// N-to-1 AXI4-Stream arbiter, round-robin per packet, with oversize detection.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int  NUM_SRC    = 4,
  parameter int  DATA_WIDTH = 64,
  parameter int  MAX_BEATS  = 256,
  localparam int SRC_W      = idx_width(NUM_SRC),
  localparam int KEEP_W     = DATA_WIDTH / 8
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          enable,
  input  logic [NUM_SRC-1:0]            src_mask,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  output logic [NUM_SRC-1:0]            s_tready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC*KEEP_W-1:0]     s_tkeep,
  input  logic [NUM_SRC-1:0]            s_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic [KEEP_W-1:0]             m_tkeep,
  output logic                          m_tlast,
  output logic [SRC_W-1:0]              m_tid,
  output logic                          busy,
  output logic                          pkt_done,
  output logic                          oversize_err,
  input  logic                          err_clr
);

  localparam int               CNT_W   = cnt_width(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BEATS + 1);

  arb_state_e         state;
  logic [SRC_W-1:0]   grant_idx;
  logic [NUM_SRC-1:0] grant_oh;
  logic [SRC_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   beat_cnt;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] sel_grant;
  logic [SRC_W-1:0]   sel_idx;
  logic               sel_valid;

  logic               xfer;
  logic               accept;
  logic [CNT_W-1:0]   cnt_next;
  logic               cnt_over;

  assign req = s_tvalid & ~src_mask;

  rr_select #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr_select (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (sel_grant),
    .grant_idx (sel_idx),
    .valid     (sel_valid)
  );

  // Outputs are forced quiet while reset is held, so a packet cut by reset
  // cannot hand over one more beat in the reset cycle.
  assign xfer = (state == ARB_XFER) && !areset;

  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tlast  = 1'b0;
    m_tid    = '0;
    s_tready = '0;
    if (xfer) begin
      m_tvalid = s_tvalid[grant_idx];
      m_tdata  = s_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      m_tkeep  = s_tkeep[grant_idx*KEEP_W +: KEEP_W];
      m_tlast  = s_tlast[grant_idx];
      m_tid    = grant_idx;
      s_tready = grant_oh & {NUM_SRC{m_tready}};
    end
  end

  assign busy     = xfer;
  assign accept   = m_tvalid & m_tready;
  assign pkt_done = accept & m_tlast;

  assign cnt_next = (beat_cnt == CNT_SAT) ? CNT_SAT : beat_cnt + 1'b1;
  assign cnt_over = cnt_next > CNT_W'(MAX_BEATS);

  always_ff @(posedge aclk) begin
    // NOTE: non-blocking so every register here updates from pre-edge values.
    if (areset) begin
      state        <= ARB_IDLE;
      rr_ptr       <= SRC_W'(NUM_SRC - 1);
      grant_idx    <= '0;
      grant_oh     <= '0;
      beat_cnt     <= '0;
      oversize_err <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (enable && sel_valid) begin
            state     <= ARB_XFER;
            grant_idx <= sel_idx;
            grant_oh  <= sel_grant;
            rr_ptr    <= sel_idx;
          end
        end
        ARB_XFER: begin
          if (accept) begin
            if (m_tlast) begin
              state    <= ARB_IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= cnt_next;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase

      // A new overflow outranks a simultaneous clear.
      if (accept && !m_tlast && cnt_over) oversize_err <= 1'b1;
      else if (err_clr)                   oversize_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: reactive source model, output monitor, hand-computed expectations.
module tb_axis_packet_arbiter;

  localparam int NS   = 4;
  localparam int DW   = 64;
  localparam int KW   = 8;
  localparam int MAXB = 4;
  localparam int TMAX = 1024;

  logic          aclk;
  logic          areset;
  logic          enable;
  logic [NS-1:0] src_mask;
  logic [NS-1:0] s_tvalid;
  logic [NS-1:0] s_tready;
  logic [NS*DW-1:0] s_tdata;
  logic [NS*KW-1:0] s_tkeep;
  logic [NS-1:0] s_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic [1:0]    m_tid;
  logic          busy;
  logic          pkt_done;
  logic          oversize_err;
  logic          err_clr;

  axis_packet_arbiter #(
    .NUM_SRC    (NS),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MAXB)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .enable       (enable),
    .src_mask     (src_mask),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tdata      (s_tdata),
    .s_tkeep      (s_tkeep),
    .s_tlast      (s_tlast),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .m_tkeep      (m_tkeep),
    .m_tlast      (m_tlast),
    .m_tid        (m_tid),
    .busy         (busy),
    .pkt_done     (pkt_done),
    .oversize_err (oversize_err),
    .err_clr      (err_clr)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          cyc;
    logic [1:0]  tid;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        done;
  } beat_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int onehot_bad = 0;
  int mirror_bad = 0;
  int pd_bad     = 0;
  int stalls     = 0;
  bit ready_mode = 0;

  int pkts_left [NS];
  int beat_idx  [NS];
  int pkt_seq   [NS];
  int plen      [NS];

  beat_t beats[$];

  bit         tr_busy   [TMAX];
  bit         tr_mvalid [TMAX];
  bit         tr_ovs    [TMAX];
  logic [3:0] tr_tready [TMAX];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void drive_sources();
    for (int i = 0; i < NS; i++) begin
      s_tvalid[i]          = pkts_left[i] > 0;
      s_tlast[i]           = (beat_idx[i] == plen[i] - 1);
      s_tdata[i*DW +: DW]  = {8'(beat_idx[i]), 8'(i), 8'(pkt_seq[i]), 40'h0};
      s_tkeep[i*KW +: KW]  = 8'hFF >> i;
    end
  endfunction

  function automatic void clear_sources();
    for (int i = 0; i < NS; i++) begin
      pkts_left[i] = 0;
      beat_idx[i]  = 0;
      pkt_seq[i]   = 0;
      plen[i]      = 1;
    end
    beats.delete();
  endfunction

  function automatic void start_src(input int i, input int n_pkts, input int len);
    pkts_left[i] = n_pkts;
    plen[i]      = len;
    beat_idx[i]  = 0;
  endfunction

  function automatic bit all_sent();
    for (int i = 0; i < NS; i++) if (pkts_left[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: sample at the falling edge, advance sources, drive new inputs just after the rising edge.
  task automatic tick();
    logic [3:0] exp_rdy;
    beat_t b;
    @(negedge aclk);
    if (cyc < TMAX) begin
      tr_busy[cyc]   = busy;
      tr_mvalid[cyc] = m_tvalid;
      tr_ovs[cyc]    = oversize_err;
      tr_tready[cyc] = s_tready;
    end
    if ($countones(s_tready) > 1) onehot_bad++;
    exp_rdy = busy ? (4'(m_tready) << m_tid) : 4'b0;
    if (s_tready !== exp_rdy) mirror_bad++;
    if (pkt_done !== (m_tvalid & m_tready & m_tlast)) pd_bad++;
    if (m_tvalid && !m_tready) stalls++;
    if (m_tvalid && m_tready) begin
      b.cyc  = cyc;
      b.tid  = m_tid;
      b.data = m_tdata;
      b.keep = m_tkeep;
      b.last = m_tlast;
      b.done = pkt_done;
      beats.push_back(b);
    end
    for (int i = 0; i < NS; i++) begin
      if (s_tvalid[i] && s_tready[i]) begin
        if (s_tlast[i]) begin
          beat_idx[i] = 0;
          pkt_seq[i]++;
          pkts_left[i]--;
        end else begin
          beat_idx[i]++;
        end
      end
    end
    @(posedge aclk);
    cyc++;
    #1;
    m_tready = ready_mode ? ((cyc % 8) >= 2) : 1'b1;
    drive_sources();
  endtask

  task automatic run_until_idle(input string tag, input int max_cyc);
    bit done = 1'b0;
    for (int n = 0; n < max_cyc && !done; n++) begin
      tick();
      done = all_sent() && !tr_busy[cyc-1];
    end
    check({tag, "_finish"}, done, 1);
  endtask

  task automatic check_pkt(input string tag, input int start, input int tid, input int len, input int seq);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      if (start + k < beats.size()) begin
        b = beats[start + k];
        check($sformatf("%s_data%0d", tag, k), b.data, {8'(k), 8'(tid), 8'(seq), 40'h0});
        check($sformatf("%s_tid%0d", tag, k), b.tid, tid);
        check($sformatf("%s_keep%0d", tag, k), b.keep, 8'hFF >> tid);
        check($sformatf("%s_last%0d", tag, k), b.last, k == len - 1);
        check($sformatf("%s_done%0d", tag, k), b.done, k == len - 1);
      end
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    clear_sources();
    drive_sources();
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int ce;
    int cr;
    aclk     = 1'b0;
    areset   = 1'b1;
    enable   = 1'b1;
    src_mask = '0;
    m_tready = 1'b1;
    err_clr  = 1'b0;
    s_tvalid = '1;
    s_tdata  = '1;
    s_tkeep  = '1;
    s_tlast  = '1;

    // Reset with every source shouting: all outputs must stay quiet.
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tkeep", m_tkeep, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tid", m_tid, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_oversize", oversize_err, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    clear_sources();
    drive_sources();
    tick();
    check("post_rst_busy", tr_busy[cyc-1], 0);
    check("post_rst_mvalid", tr_mvalid[cyc-1], 0);
    check("post_rst_ovs", tr_ovs[cyc-1], 0);

    // Single 8-beat packet from source 0.
    clear_sources();
    start_src(0, 1, 8);
    drive_sources();
    c0 = cyc;
    run_until_idle("single", 40);
    check("single_count", beats.size(), 8);
    if (beats.size() > 0) check("single_first_lat", beats[0].cyc - c0, 1);
    check_pkt("single", 0, 0, 8, 0);
    check("single_busy_last", tr_busy[c0+8], 1);
    check("single_busy_fall", tr_busy[c0+9], 0);
    clear_err();

    // Round-robin: four sources, two 2-beat packets each.
    do_reset();
    clear_sources();
    for (int i = 0; i < NS; i++) start_src(i, 2, 2);
    drive_sources();
    c0 = cyc;
    run_until_idle("rr", 80);
    check("rr_count", beats.size(), 16);
    for (int p = 0; p < 8; p++) begin
      check_pkt($sformatf("rr_p%0d", p), 2 * p, p % 4, 2, p / 4);
      if (2 * p + 1 < beats.size()) begin
        check($sformatf("rr_cyc%0d_b0", p), beats[2*p].cyc, c0 + 1 + 3 * p);
        check($sformatf("rr_cyc%0d_b1", p), beats[2*p+1].cyc, c0 + 2 + 3 * p);
      end
    end
    check("rr_no_ovs", tr_ovs[cyc-1], 0);

    // Backpressure: 2 low / 6 high on m_tready.
    clear_sources();
    ready_mode = 1'b1;
    m_tready   = (cyc % 8) >= 2;
    stalls     = 0;
    start_src(0, 1, 8);
    drive_sources();
    run_until_idle("bp", 60);
    ready_mode = 1'b0;
    m_tready   = 1'b1;
    check("bp_count", beats.size(), 8);
    check_pkt("bp", 0, 0, 8, 0);
    check("bp_stalled", stalls > 0, 1);

    // Mask source 1.
    do_reset();
    clear_sources();
    src_mask = 4'b0010;
    start_src(0, 2, 2);
    start_src(1, 1, 2);
    start_src(2, 1, 2);
    start_src(3, 1, 2);
    drive_sources();
    repeat (20) tick();
    check("mask_count", beats.size(), 8);
    check_pkt("mask_p0", 0, 0, 2, 0);
    check_pkt("mask_p1", 2, 2, 2, 0);
    check_pkt("mask_p2", 4, 3, 2, 0);
    check_pkt("mask_p3", 6, 0, 2, 1);
    check("mask_held", pkts_left[1], 1);
    check("mask_idle", tr_busy[cyc-1], 0);
    src_mask = 4'b0000;
    run_until_idle("mask_release", 20);
    check("mask_release_count", beats.size(), 10);
    check_pkt("mask_p4", 8, 1, 2, 0);

    // Enable dropped mid-packet.
    clear_sources();
    start_src(0, 1, 8);
    start_src(1, 1, 2);
    drive_sources();
    c0 = cyc;
    repeat (3) tick();
    enable = 1'b0;
    repeat (12) tick();
    check("en_count", beats.size(), 8);
    check_pkt("en", 0, 0, 8, 0);
    check("en_busy_fall", tr_busy[c0+9], 0);
    check("en_idle", tr_busy[cyc-1], 0);
    check("en_held", pkts_left[1], 1);
    enable = 1'b1;
    ce = cyc;
    run_until_idle("en_resume", 20);
    check("en_resume_count", beats.size(), 10);
    check_pkt("en_p1", 8, 1, 2, 0);
    if (beats.size() > 8) check("en_resume_lat", beats[8].cyc - ce, 1);
    clear_err();

    // Oversize: 6-beat packet against MAX_BEATS=4.
    clear_sources();
    start_src(0, 1, 6);
    drive_sources();
    c0 = cyc;
    run_until_idle("ovs", 30);
    check("ovs_count", beats.size(), 6);
    check_pkt("ovs", 0, 0, 6, 0);
    check("ovs_before", tr_ovs[c0+5], 0);
    check("ovs_rise", tr_ovs[c0+6], 1);
    check("ovs_sticky", tr_ovs[cyc-1], 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    check("ovs_clr", tr_ovs[cyc-1], 0);

    // Set and clear in the same cycle: set wins, then the held clear drops it.
    clear_sources();
    start_src(0, 1, 6);
    err_clr = 1'b1;
    drive_sources();
    c0 = cyc;
    run_until_idle("ovs_both", 30);
    err_clr = 1'b0;
    check("ovs_both_pre", tr_ovs[c0+5], 0);
    check("ovs_set_wins", tr_ovs[c0+6], 1);
    check("ovs_clr_after", tr_ovs[c0+7], 0);

    // Exactly MAX_BEATS beats never flags.
    clear_sources();
    start_src(0, 1, 4);
    drive_sources();
    run_until_idle("ovs_max", 20);
    check("ovs_at_max", tr_ovs[cyc-1], 0);

    // Reset during beat 3 of 8.
    clear_sources();
    start_src(0, 1, 8);
    drive_sources();
    c0 = cyc;
    repeat (3) tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("rst_mid_pre", beats.size(), 2);
    clear_sources();
    start_src(0, 1, 8);
    start_src(3, 1, 2);
    drive_sources();
    cr = cyc;
    run_until_idle("rst_mid", 40);
    check("rst_mid_mvalid_in", tr_mvalid[c0+3], 0);
    check("rst_mid_tready_in", tr_tready[c0+3], 0);
    check("rst_mid_mvalid", tr_mvalid[cr], 0);
    check("rst_mid_tready", tr_tready[cr], 0);
    check("rst_mid_busy", tr_busy[cr], 0);
    check("rst_mid_count", beats.size(), 10);
    check_pkt("rst_p0", 0, 0, 8, 0);
    check_pkt("rst_p1", 8, 3, 2, 0);
    if (beats.size() > 0) check("rst_mid_lat", beats[0].cyc - cr, 1);

    check("tready_onehot", onehot_bad, 0);
    check("tready_mirror", mirror_bad, 0);
    check("pkt_done_pulse", pd_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
